// File: rtl/uart_pkg.sv
// Shared types and constants for the 8n1 UART receive path.
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } uart_rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte-side interface of the UART receiver: received data, strobes and debug state.
interface uart_rx_if;
    import uart_pkg::*;

    // o_rx_valid is a single-cycle strobe with no ready: the consumer must take
    // o_rx_data on the cycle o_rx_valid is high. o_rx_frame_err never coincides with it.
    logic [UART_DATA_BITS-1:0] o_rx_data;
    logic                      o_rx_valid;
    logic                      o_rx_frame_err;
    logic                      o_rx_busy;
    uart_rx_state_t            dbg_state;

    modport master (
        output o_rx_data,
        output o_rx_valid,
        output o_rx_frame_err,
        output o_rx_busy,
        output dbg_state
    );

    modport slave (
        input o_rx_data,
        input o_rx_valid,
        input o_rx_frame_err,
        input o_rx_busy,
        input dbg_state
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input, reset to RESET_VAL.
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8n1 LSB-first UART receiver with mid-bit sampling and stop-bit checking.
// Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 majority sampling around each bit centre.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_rx_data,
    uart_rx_if.master rx_if
);

    localparam int CNT_BITS = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_BITS-1:0] CNT_HALF = CNT_BITS'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(CLKS_PER_BIT - 1);
    localparam logic [2:0]          LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_rx_state_t            state;
    logic [CNT_BITS-1:0]       clk_cnt;
    logic [2:0]                bit_cnt;
    logic [UART_DATA_BITS-1:0] shift_reg;
    logic [UART_DATA_BITS-1:0] data_q;
    logic                      valid_q;
    logic                      ferr_q;
    logic                      busy_q;
    logic                      rx_s;
    logic                      bit_val;

    uart_rx_sync #(.RESET_VAL(UART_IDLE_LEVEL)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (i_rx_data),
        .q     (rx_s)
    );

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] early;

    // Cleared in IDLE so a short START half-period still votes with the start level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            early <= 2'b00;
        end else if (state == ST_IDLE) begin
            early <= 2'b00;
        end else if (clk_cnt == CNT_BITS'(2)) begin
            early[1] <= rx_s;
        end else if (clk_cnt == CNT_BITS'(1)) begin
            early[0] <= rx_s;
        end
    end

    assign bit_val = maj3(early[1], early[0], rx_s);
`else
    assign bit_val = rx_s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_s != UART_IDLE_LEVEL) begin
                        state   <= ST_START;
                        clk_cnt <= CNT_HALF;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (clk_cnt != '0) begin
                        clk_cnt <= clk_cnt - 1'b1;
                    end else if (bit_val != UART_IDLE_LEVEL) begin
                        state   <= ST_DATA;
                        clk_cnt <= CNT_FULL;
                        bit_cnt <= '0;
                    end else begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (clk_cnt != '0) begin
                        clk_cnt <= clk_cnt - 1'b1;
                    end else begin
                        shift_reg[bit_cnt] <= bit_val;
                        clk_cnt            <= CNT_FULL;
                        if (bit_cnt == LAST_BIT) begin
                            state <= ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (clk_cnt != '0) begin
                        clk_cnt <= clk_cnt - 1'b1;
                    end else if (bit_val == UART_IDLE_LEVEL) begin
                        data_q  <= shift_reg;
                        valid_q <= 1'b1;
                        state   <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        ferr_q <= 1'b1;
                        state  <= ST_WAIT_IDLE;
                    end
                end
                ST_WAIT_IDLE: begin
                    // A held-low line (break) must not retrigger start detection.
                    if (rx_s == UART_IDLE_LEVEL) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx_if.o_rx_data      = data_q;
    assign rx_if.o_rx_valid     = valid_q;
    assign rx_if.o_rx_frame_err = ferr_q;
    assign rx_if.o_rx_busy      = busy_q;
    assign rx_if.dbg_state      = state;

endmodule
